// File: rtl/ps2_teclado_rx.sv
// ---------------------------------------------------------------------------
// ps2_teclado_rx
//
// PS/2 keyboard receiver that feeds the PicoBlaze keyboard input port.
// It synchronizes the raw PS/2 lines, removes glitches from the PS/2 clock,
// deframes 11-bit frames (start, 8 data LSB first, odd parity, stop),
// discards break (F0) and extended (E0) prefixes and holds the most recent
// make code until the processor acknowledges it.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   ps2_clk      raw PS/2 clock from the keyboard (asynchronous)
//   ps2_data     raw PS/2 data from the keyboard (asynchronous)
//   leer         one-cycle read acknowledge from the port decode
//   dato_teclado last make scan code received
//   tecla_valid  dato_teclado holds an unread code
//   ext_key      last make code was E0-prefixed
//   overrun      sticky: a make code overwrote an unread one
//   frame_err    one-cycle pulse per aborted or rejected frame
// ---------------------------------------------------------------------------
module ps2_teclado_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       leer,
    output logic [7:0] dato_teclado,
    output logic       tecla_valid,
    output logic       ext_key,
    output logic       overrun,
    output logic       frame_err
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    // -----------------------------------------------------------------------
    // Input synchronizers. They reset to 1 because an idle PS/2 line is high.
    // -----------------------------------------------------------------------
    logic clk_meta, clk_sync;
    logic data_meta, data_sync;

    // NOTE: sequential state is always assigned with <= so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // -----------------------------------------------------------------------
    // Clock glitch filter: count consecutive samples that differ from the
    // filtered value; any sample that agrees again restarts the count.
    // -----------------------------------------------------------------------
    logic             clk_filt;
    logic             clk_filt_q;
    logic [FLT_W-1:0] flt_cnt;
    logic             fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_filt   <= 1'b1;
            clk_filt_q <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_filt_q <= clk_filt;
            if (clk_sync == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_filt <= clk_sync;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // One-cycle strobe on the first cycle the filtered clock reads low.
    assign fall = clk_filt_q & ~clk_filt;

    // -----------------------------------------------------------------------
    // Deframing FSM with mid-frame timeout.
    // -----------------------------------------------------------------------
    logic [1:0]       state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_bit;
    logic [TMO_W-1:0] tmo_cnt;
    logic             byte_strobe;
    logic [7:0]       rx_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            tmo_cnt     <= '0;
            byte_strobe <= 1'b0;
            rx_byte     <= '0;
            frame_err   <= 1'b0;
        end else begin
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;

            if (state == ST_IDLE || fall) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (fall && !data_sync) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        shift_reg <= {data_sync, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (fall) begin
                        parity_bit <= data_sync;
                        state      <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall) begin
                        // Odd parity: data plus parity bit XOR to 1.
                        if (data_sync && (^{shift_reg, parity_bit})) begin
                            byte_strobe <= 1'b1;
                            rx_byte     <= shift_reg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Abort a stalled frame; placed last so it overrides the case.
            if (state != ST_IDLE && !fall && tmo_cnt == TMO_LAST) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scan code decoder and read handshake.
    // -----------------------------------------------------------------------
    logic brk;
    logic ext_pend;
    logic is_make;

    assign is_make = byte_strobe && (rx_byte != CODE_BREAK) &&
                     (rx_byte != CODE_EXT) && !brk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk          <= 1'b0;
            ext_pend     <= 1'b0;
            dato_teclado <= '0;
            tecla_valid  <= 1'b0;
            ext_key      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (byte_strobe) begin
                if (rx_byte == CODE_BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == CODE_EXT) begin
                    ext_pend <= 1'b1;
                end else if (brk) begin
                    // Release code: swallow it and forget the prefixes.
                    brk      <= 1'b0;
                    ext_pend <= 1'b0;
                end else begin
                    dato_teclado <= rx_byte;
                    ext_key      <= ext_pend;
                    ext_pend     <= 1'b0;
                end
            end

            // A new make beats a simultaneous acknowledge; an acknowledge
            // that lands with a make still counts as reading the old code.
            if (is_make) begin
                tecla_valid <= 1'b1;
                if (tecla_valid && !leer) begin
                    overrun <= 1'b1;
                end else if (tecla_valid && leer) begin
                    overrun <= 1'b0;
                end
            end else if (leer && tecla_valid) begin
                tecla_valid <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_teclado_rx
//
// Directed bench for ps2_teclado_rx. Frames are bit-banged on ps2_clk /
// ps2_data; every expected make code is queued when its frame is sent and
// popped when the receiver has had time to present it.
// ---------------------------------------------------------------------------
module tb_ps2_teclado_rx;

    localparam int FLT  = 8;
    localparam int TMO  = 2000;
    localparam int HALF = 20;          // clk cycles per PS/2 clock half period
    localparam int LAT  = 2 + FLT + 2; // raw fall -> decoder output visible

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } make_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       leer;
    logic [7:0] dato_teclado;
    logic       tecla_valid;
    logic       ext_key;
    logic       overrun;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int err_base;

    make_t exp_q[$];

    ps2_teclado_rx #(
        .FILTER_LEN  (FLT),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .leer         (leer),
        .dato_teclado (dato_teclado),
        .tecla_valid  (tecla_valid),
        .ext_key      (ext_key),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Count every cycle frame_err is seen high.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Start, data LSB first and parity (odd parity unless par_flip).
    task automatic send_head(input logic [7:0] b, input logic par_flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ par_flip);
    endtask

    task automatic idle_gap();
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        send_head(b, par_flip);
        ps2_bit(stop);
        idle_gap();
    endtask

    // Stop bit with cycle-exact observation of the make; optionally raises
    // leer in exactly the cycle the make is taken.
    task automatic stop_bit_timed(input logic with_leer, input logic tv_before);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check("tv_before_make", 32'(tecla_valid), 32'(tv_before));
        leer = with_leer;
        @(negedge clk);
        leer = 1'b0;
        check("tv_at_make", 32'(tecla_valid), 1);
        repeat (HALF - LAT) @(negedge clk);
        ps2_clk = 1'b1;
        idle_gap();
    endtask

    task automatic expect_make(input logic ext, input logic [7:0] code);
        make_t m;
        m.ext  = ext;
        m.code = code;
        exp_q.push_back(m);
    endtask

    task automatic check_make(input string tag);
        make_t m;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            m = exp_q.pop_front();
            check({tag, "_dato"}, 32'(dato_teclado), 32'(m.code));
            check({tag, "_ext"}, 32'(ext_key), 32'(m.ext));
            check({tag, "_valid"}, 32'(tecla_valid), 1);
        end
    endtask

    task automatic pulse_leer();
        leer = 1'b1;
        @(negedge clk);
        leer = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dato"}, 32'(dato_teclado), 0);
        check({tag, "_valid"}, 32'(tecla_valid), 0);
        check({tag, "_ext"}, 32'(ext_key), 0);
        check({tag, "_ovr"}, 32'(overrun), 0);
        check({tag, "_ferr"}, 32'(frame_err), 0);
    endtask

    initial begin
        reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        leer     = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("por");
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Load some state (code, overrun, pending E0) so the reset has work.
        expect_make(1'b0, 8'h55);
        send_frame(8'h55, 1'b0, 1'b1);
        check_make("pre55");
        expect_make(1'b0, 8'h66);
        send_frame(8'h66, 1'b0, 1'b1);
        check_make("pre66");
        check("pre_overrun", 32'(overrun), 1);
        send_frame(8'hE0, 1'b0, 1'b1);

        // Reset in the middle of a frame, after 5 data bits.
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        ps2_data = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (3) @(negedge clk);
        check_all_zero("midrst_hold");
        reset = 1'b1;
        exp_q.delete();
        repeat (5) @(negedge clk);
        err_base = err_cnt;

        // 0x1C after reset, with exact make latency.
        expect_make(1'b0, 8'h1C);
        send_head(8'h1C, 1'b0);
        stop_bit_timed(1'b0, 1'b0);
        check_make("t1_1c");
        check("t1_no_ferr", 32'(err_cnt - err_base), 0);
        pulse_leer();
        check("t1_leer_valid", 32'(tecla_valid), 0);

        // Make, then break sequence for the same key: no overrun.
        expect_make(1'b0, 8'h1C);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_make("t2_1c");
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t2_valid", 32'(tecla_valid), 1);
        check("t2_dato", 32'(dato_teclado), 32'h1C);
        check("t2_ovr", 32'(overrun), 0);
        pulse_leer();
        check("t2_leer_valid", 32'(tecla_valid), 0);
        check("t2_leer_dato", 32'(dato_teclado), 32'h1C);

        // Extended make, then a plain make overwriting it unread.
        send_frame(8'hE0, 1'b0, 1'b1);
        expect_make(1'b1, 8'h75);
        send_frame(8'h75, 1'b0, 1'b1);
        check_make("t3_e075");
        check("t3_ovr0", 32'(overrun), 0);
        expect_make(1'b0, 8'h74);
        send_frame(8'h74, 1'b0, 1'b1);
        check_make("t3_74");
        check("t3_ovr1", 32'(overrun), 1);
        pulse_leer();
        check("t3_leer_ovr", 32'(overrun), 0);
        check("t3_leer_valid", 32'(tecla_valid), 0);

        // Parity error and stop-bit error frames.
        err_base = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("t4_ferr_cnt", 32'(err_cnt - err_base), 2);
        check("t4_valid", 32'(tecla_valid), 0);
        expect_make(1'b0, 8'h32);
        send_frame(8'h32, 1'b0, 1'b1);
        check_make("t4_32");

        // Stalled frame: start plus 4 data bits, then silence.
        err_base = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TMO + 10) @(negedge clk);
        check("t5_ferr_cnt", 32'(err_cnt - err_base), 1);
        expect_make(1'b0, 8'h29);
        send_frame(8'h29, 1'b0, 1'b1);
        check_make("t5_29");
        check("t5_ovr", 32'(overrun), 1);
        pulse_leer();

        // Glitches in IDLE, then a make that coincides with leer.
        expect_make(1'b0, 8'h2A);
        send_frame(8'h2A, 1'b0, 1'b1);
        check_make("t6_2a");
        err_base = err_cnt;
        ps2_data = 1'b0;
        for (int g = 0; g < 3; g++) begin
            ps2_clk = 1'b0;
            repeat (FLT - 2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        check("t6_glitch_ferr", 32'(err_cnt - err_base), 0);
        check("t6_glitch_dato", 32'(dato_teclado), 32'h2A);
        check("t6_glitch_valid", 32'(tecla_valid), 1);
        expect_make(1'b0, 8'h1B);
        send_head(8'h1B, 1'b0);
        stop_bit_timed(1'b1, 1'b1);
        check_make("t6_1b");
        check("t6_ovr", 32'(overrun), 0);
        check("t6_ferr", 32'(err_cnt - err_base), 0);

        check("sb_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
